// File: rtl/executor_rega.sv
// executor_rega: irrigation valve sequencer (open/settle/irrigate/close); define PAUSA_NIVEL_EN to pause instead of cancel on tank drop
module executor_rega #(
  parameter int T_ABRE  = 4,
  parameter int T_ASP   = 200,
  parameter int T_GOT   = 600,
  parameter int T_FECHA = 4,
  parameter int W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rega,
  input  logic       erro,
  input  logic [1:0] mef1,
  output logic       valv_asp,
  output logic       valv_got,
  output logic       ocupado,
  output logic       concluido,
  output logic       alarme,
  output logic [1:0] modo
);
  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] ABRINDO  = 3'd1;
  localparam logic [2:0] REGANDO  = 3'd2;
  localparam logic [2:0] FECHANDO = 3'd3;
  localparam logic [2:0] FALHA    = 3'd4;
  localparam logic [W-1:0] LD_ABRE  = W'(T_ABRE - 1);
  localparam logic [W-1:0] LD_ASP   = W'(T_ASP - 1);
  localparam logic [W-1:0] LD_GOT   = W'(T_GOT - 1);
  localparam logic [W-1:0] LD_FECHA = W'(T_FECHA - 1);
  logic [2:0] st, ns;
  logic [W-1:0] cnt, cnt_n, dec;
  logic [1:0] modo_n;
  logic canc, canc_n, pausa, valv, zero, tank, start;
  assign zero  = cnt == '0;
  assign dec   = zero ? '0 : cnt - 1'b1;
  assign tank  = mef1 != 2'b11;
  assign start = (rega == 2'b10 || rega == 2'b01) && !erro && !tank;
  always_comb begin
    ns     = st;
    cnt_n  = dec;
    modo_n = modo;
    canc_n = canc;
    pausa  = 1'b0;
    case (st)
      OCIOSO: begin
        cnt_n = '0;
        if (start) begin
          ns     = ABRINDO;
          cnt_n  = LD_ABRE;
          modo_n = rega;
          canc_n = 1'b0;
        end
      end
      ABRINDO:
        if (erro) ns = FALHA;
        else if (rega == 2'b00 || tank) begin
          ns     = FECHANDO;
          cnt_n  = LD_FECHA;
          canc_n = 1'b1;
        end else if (zero) begin
          ns    = REGANDO;
          cnt_n = modo == 2'b10 ? LD_ASP : LD_GOT;
        end
      REGANDO:
        if (erro) ns = FALHA;
        else if (rega == 2'b00) begin
          ns     = FECHANDO;
          cnt_n  = LD_FECHA;
          canc_n = 1'b1;
        end else if (tank) begin
`ifdef PAUSA_NIVEL_EN
          pausa = 1'b1;
          cnt_n = cnt;
`else
          ns     = FECHANDO;
          cnt_n  = LD_FECHA;
          canc_n = 1'b1;
`endif
        end else if (zero) begin
          ns    = FECHANDO;
          cnt_n = LD_FECHA;
        end
      FECHANDO:
        if (zero) ns = OCIOSO;
      FALHA: begin
        cnt_n = '0;
        if (!erro && rega == 2'b00) ns = OCIOSO;
      end
      default: ns = OCIOSO;
    endcase
    if (ns == OCIOSO) modo_n = 2'b00;
  end
  assign valv = (ns == ABRINDO || ns == REGANDO) && !pausa;
  // outputs are decoded from next-state so every output is a flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= OCIOSO;
      cnt       <= '0;
      modo      <= 2'b00;
      canc      <= 1'b0;
      valv_asp  <= 1'b0;
      valv_got  <= 1'b0;
      ocupado   <= 1'b0;
      concluido <= 1'b0;
      alarme    <= 1'b0;
    end else begin
      st        <= ns;
      cnt       <= cnt_n;
      modo      <= modo_n;
      canc      <= canc_n;
      valv_asp  <= valv && modo_n == 2'b10;
      valv_got  <= valv && modo_n == 2'b01;
      ocupado   <= ns != OCIOSO;
      concluido <= st == FECHANDO && ns == OCIOSO && !canc;
      alarme    <= ns == FALHA;
    end
  end
endmodule

// File: tb/tb_executor_rega.sv
// tb_executor_rega: directed scoreboard bench for executor_rega with short timing parameters
module tb_executor_rega;
  logic clk = 1'b0, reset = 1'b0, erro = 1'b0;
  logic [1:0] rega = 2'b00, mef1 = 2'b11;
  logic valv_asp, valv_got, ocupado, concluido, alarme;
  logic [1:0] modo;
  executor_rega #(.T_ABRE(2), .T_ASP(5), .T_GOT(8), .T_FECHA(2), .W(16)) dut (
    .clk(clk), .reset(reset), .rega(rega), .erro(erro), .mef1(mef1),
    .valv_asp(valv_asp), .valv_got(valv_got), .ocupado(ocupado),
    .concluido(concluido), .alarme(alarme), .modo(modo)
  );
  always #5 clk = ~clk;
  int exp_q[$];
  int passed = 0, failed = 0, total = 0;
  int n_asp, n_got, n_ocu, n_conc, n_alm, n_both, n_modo;
  logic [1:0] cur_modo;
  task automatic clr(input logic [1:0] m);
    n_asp = 0; n_got = 0; n_ocu = 0; n_conc = 0; n_alm = 0; n_both = 0; n_modo = 0;
    cur_modo = m;
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_asp  += int'(valv_asp);
      n_got  += int'(valv_got);
      n_ocu  += int'(ocupado);
      n_conc += int'(concluido);
      n_alm  += int'(alarme);
      n_both += int'(valv_asp & valv_got);
      n_modo += int'(modo !== (ocupado ? cur_modo : 2'b00));
    end
  endtask
  task automatic chk(input string tag, input int obs);
    int e;
    total++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL %s: observed %0d expected <empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passed++;
      else begin
        failed++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask
  task automatic push7(input int a, input int g, input int o, input int c, input int al);
    exp_q.push_back(a); exp_q.push_back(g); exp_q.push_back(o); exp_q.push_back(c);
    exp_q.push_back(al); exp_q.push_back(0); exp_q.push_back(0);
  endtask
  task automatic chk7(input string p);
    chk({p, "_asp"}, n_asp);
    chk({p, "_got"}, n_got);
    chk({p, "_ocupado"}, n_ocu);
    chk({p, "_concluido"}, n_conc);
    chk({p, "_alarme"}, n_alm);
    chk({p, "_both"}, n_both);
    chk({p, "_modo"}, n_modo);
  endtask
  task automatic start(input logic [1:0] m);
    rega = m;
    step(1);
    rega = 2'b11;
  endtask
  initial begin
    #12;
    exp_q.push_back(0);
    chk("reset_outs", int'({valv_asp, valv_got, ocupado, concluido, alarme, modo}));
    @(negedge clk);
    reset = 1'b1;
    clr(2'b10);
    push7(7, 0, 9, 1, 0);
    start(2'b10);
    step(19);
    chk7("asp");
    clr(2'b01);
    push7(0, 10, 12, 1, 0);
    start(2'b01);
    step(19);
    chk7("got");
    clr(2'b10);
    start(2'b10);
    step(4);
    exp_q.push_back(1);
    chk("err_pre_asp", int'(valv_asp));
    erro = 1'b1;
    step(1);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
    chk("err_asp", int'(valv_asp));
    chk("err_alarme", int'(alarme));
    chk("err_ocupado", int'(ocupado));
    erro = 1'b0;
    step(2);
    exp_q.push_back(1);
    chk("falha_hold", int'(alarme));
    rega = 2'b00;
    step(1);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    chk("falha_exit_alarme", int'(alarme));
    chk("falha_exit_ocupado", int'(ocupado));
    chk("err_concluido", n_conc);
    chk("err_both", n_both);
    clr(2'b10);
    push7(4, 0, 6, 0, 0);
    start(2'b10);
    step(3);
    rega = 2'b00;
    step(10);
    chk7("cancel");
    clr(2'b10);
`ifdef PAUSA_NIVEL_EN
    push7(7, 0, 12, 1, 0);
`else
    push7(4, 0, 6, 0, 0);
`endif
    start(2'b10);
    step(3);
    mef1 = 2'b10;
    step(3);
    mef1 = 2'b11;
    step(14);
    chk7("tank");
    clr(2'b10);
    start(2'b10);
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(0);
    chk("reset_mid_outs", int'({valv_asp, valv_got, ocupado, concluido, alarme, modo}));
    @(negedge clk);
    reset = 1'b1;
    clr(2'b00);
    rega = 2'b11;
    step(6);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    chk("rega11_ocupado", n_ocu);
    chk("rega11_valves", n_asp + n_got);
    chk("rega11_concluido", n_conc);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/executor_rega.md
Name: executor_rega

Overview:
- Sequencer on the consumer side of the validated irrigation command pair: `rega[1:0]` and `erro`.
- Turns a validated command into a timed valve sequence: open, settle, irrigate for a mode-specific duration, close, report completion.
- Sits between the command validator and the physical sprinkler/drip valve drivers.
- Monitors tank state `mef1` during operation.

Parameters:
- T_ABRE, 4: valve-open settling cycles (≥1).
- T_ASP, 200: irrigation cycles in sprinkler mode (≥1).
- T_GOT, 600: irrigation cycles in drip mode (≥1).
- T_FECHA, 4: valve-close settling cycles (≥1).
- W, 16: counter width; every T_* must be < 2^W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rega  in  2  validated command: 10 = sprinkler, 01 = drip, 00/11 = none.
- erro  in  1  validator error flag.
- mef1  in  2  tank state; 11 = level permits irrigation.
- valv_asp  out  1  sprinkler valve drive.
- valv_got  out  1  drip valve drive.
- ocupado  out  1  high whenever the state is not OCIOSO.
- concluido  out  1  one-cycle pulse on normal completion.
- alarme  out  1  sticky fault flag.
- modo  out  2  latched mode of the current cycle (10/01), 00 when idle.

Behaviour:
- Reset (async, `reset`=0):
  - state = OCIOSO; counter = 0; `modo` = 00.
  - All outputs 0.
- All registers update on rising `clk`. Outputs are registered.
- States:
  - OCIOSO
  - ABRINDO
  - REGANDO
  - FECHANDO
  - FALHA
- OCIOSO:
  - Start condition: `rega` is 10 or 01, `erro`=0 and `mef1`=11.
  - On start: latch `rega` into `modo`, load counter = T_ABRE-1, go to ABRINDO.
  - Otherwise stay. `rega` of 00 or 11 never starts a cycle.
- ABRINDO:
  - Valve for `modo` is driven high on entry.
  - Counter decrements each cycle. At 0: load T_ASP-1 or T_GOT-1 per `modo`, go to REGANDO.
- REGANDO:
  - Valve stays high; counter decrements.
  - At 0: go to FECHANDO, load T_FECHA-1.
- FECHANDO:
  - Both valves low; counter decrements.
  - At 0: go to OCIOSO, pulse `concluido` for exactly 1 cycle, clear `modo`.
- Timing:
  - Total busy time = T_ABRE + T_ASP/T_GOT + T_FECHA cycles, measured from the first cycle `ocupado`=1.
  - `concluido` is asserted in the first OCIOSO cycle.
- Command changes mid-cycle:
  - `rega` changes after the latch are ignored; the mode is fixed per cycle.
  - `rega`=00 during ABRINDO or REGANDO is a cancel: go to FECHANDO immediately with T_FECHA-1 loaded; no `concluido`.
- `erro`=1 while in ABRINDO or REGANDO:
  - Both valves drop in the same cycle the state leaves, i.e. next edge.
  - Go to FALHA and set `alarme`=1.
- FALHA:
  - Valves 0, `ocupado`=1.
  - Leaves only when `erro`=0 and `rega`=00 for one sampled cycle; then returns to OCIOSO and clears `alarme`.
- Tank drop in REGANDO (`mef1`≠11): see Optional Feature.
  - In ABRINDO a tank drop always acts as a cancel (→ FECHANDO).
- Mutual exclusion: `valv_asp` and `valv_got` are never both 1, in any state or cycle.
- Priority when events coincide on one edge: reset > `erro` > cancel > tank drop > counter expiry.
- Reset mid-operation: valves drop asynchronously, no completion pulse.
- Counters saturate at 0; no wrap-around underflow.

Optional Feature:
- Macro: PAUSA_NIVEL_EN.
- Defined:
  - `mef1`≠11 in REGANDO freezes the counter and drops the valve; the state stays REGANDO.
  - When `mef1` returns to 11 the valve reopens and counting resumes from the held value.
  - `ocupado` stays 1 throughout the pause.
- Undefined: `mef1`≠11 in REGANDO acts as a cancel (→ FECHANDO, no `concluido`, no alarm).

Test Plan:
- Parameters T_ABRE=2, T_ASP=5, T_FECHA=2. Stimulus: `rega`=10, `mef1`=11, `erro`=0 for 1 cycle. Required:
  - `valv_asp`=1 for 7 cycles.
  - 2 closing cycles follow.
  - `concluido` pulses once.
  - `ocupado` is high for exactly 9 cycles.
- Drip mode with T_GOT=8 → `valv_got`=1 for 10 cycles, `valv_asp`=0 throughout, `modo`=01 while busy.
- `erro`=1 on the 3rd REGANDO cycle → valves 0 next edge, state FALHA, `alarme`=1. Then `erro`=0 and `rega`=00 → OCIOSO, `alarme`=0, no `concluido`.
- `rega`=00 mid-REGANDO → FECHANDO for T_FECHA cycles, return to OCIOSO, no `concluido`.
- `mef1`=10 for 3 cycles mid-REGANDO:
  - With PAUSA_NIVEL_EN: valve is low for 3 cycles and total busy time grows by 3.
  - Without: cancel path is taken.
- Async reset asserted mid-ABRINDO (between edges) → all outputs 0 immediately. After release, `rega`=11 → stays OCIOSO.
